ieee754_op_sequencer: RTL and testbench

IEEE754_OP_SEQUENCER -- requirements
Module: ieee754_op_sequencer

---
 rtl/ieee754_op_sequencer_pkg.sv | 52 +++++
 rtl/ieee754_op_sequencer_core.sv | 113 +++++++++++
 rtl/ieee754_op_sequencer.sv | 137 +++++++++++++
 tb/tb_ieee754_op_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ieee754_op_sequencer_pkg.sv
// Shared encodings, constants and the round/pack helper for the IEEE754 op sequencer.
// Used by the sequencer FSM and by its arithmetic core.
package ieee754_op_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_MUL = 2'b10,
      OP_DIV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [31:0] QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] PINF    = 32'h7F80_0000;
   localparam logic [7:0]  EXP_MAX = 8'hFF;

   // out_flags = {invalid, div_by_zero, bypass}
   localparam int FLAG_INVALID  = 2;
   localparam int FLAG_DIV_ZERO = 1;
   localparam int FLAG_BYPASS   = 0;

   // man[26] is the leading one, man[25:3] the fraction, man[2:0] guard/round/sticky.
   // Round to nearest even; overflow saturates to infinity, underflow flushes to zero.
   function automatic logic [31:0] round_pack(input logic              sign,
                                              input logic signed [9:0] exp_in,
                                              input logic [26:0]       man);
      logic [24:0]        rnd;
      logic signed [9:0]  exp_r;
      logic [22:0]        frac;
      logic               up;
      up    = man[2] & (man[1] | man[0] | man[3]);
      rnd   = {1'b0, man[26:3]} + {24'd0, up};
      exp_r = exp_in;
      frac  = rnd[22:0];
      if (rnd[24]) begin
         exp_r = exp_in + 10'sd1;
         frac  = rnd[23:1];
      end
      if (exp_r >= 10'sd255)
         round_pack = {sign, EXP_MAX, 23'd0};
      else if (exp_r <= 10'sd0)
         round_pack = {sign, 31'd0};
      else
         round_pack = {sign, exp_r[7:0], frac};
   endfunction

endpackage

// File: rtl/ieee754_op_sequencer_core.sv
// Combinational single-precision add/sub/mul/div for normal operands.
// Zero, denormal, NaN and Inf operands are resolved by the caller before this result is used.
module ieee754_op_sequencer_core
   import ieee754_op_sequencer_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  op_e         op_sel_i,
   output logic [31:0] result_o
);

   logic        sa, sb, sb_eff;
   logic [7:0]  ea, eb;
   logic [23:0] ma, mb;

   assign sa     = a_i[31];
   assign sb     = b_i[31];
   assign ea     = a_i[30:23];
   assign eb     = b_i[30:23];
   assign ma     = {1'b1, a_i[22:0]};
   assign mb     = {1'b1, b_i[22:0]};
   assign sb_eff = sb ^ (op_sel_i == OP_SUB);

   logic              a_big, s_big, sticky;
   logic [7:0]        e_big, e_sml, diff;
   logic [23:0]       m_big, m_sml;
   logic [26:0]       sml_ext, sml_sh, lost_mask, add_man;
   logic [27:0]       sum;
   logic [4:0]        lz;
   logic signed [9:0] add_exp;
   logic [31:0]       add_res;

   always_comb begin
      a_big     = {ea, ma} >= {eb, mb};
      e_big     = a_big ? ea : eb;
      e_sml     = a_big ? eb : ea;
      m_big     = a_big ? ma : mb;
      m_sml     = a_big ? mb : ma;
      s_big     = a_big ? sa : sb_eff;
      diff      = e_big - e_sml;
      sml_ext   = {m_sml, 3'b000};
      lost_mask = '0;
      if (diff >= 8'd27) begin
         sml_sh = '0;
         sticky = |m_sml;
      end else begin
         sml_sh    = sml_ext >> diff;
         lost_mask = (27'd1 << diff) - 27'd1;
         sticky    = |(sml_ext & lost_mask);
      end
      sml_sh = sml_sh | {26'd0, sticky};
      if (sa == sb_eff)
         sum = {1'b0, m_big, 3'b000} + {1'b0, sml_sh};
      else
         sum = {1'b0, m_big, 3'b000} - {1'b0, sml_sh};
      lz = '0;
      for (int i = 0; i < 27; i++) begin
         if (sum[i]) lz = 5'(26 - i);
      end
      if (sum[27]) begin
         add_man = {sum[27:2], sum[1] | sum[0]};
         add_exp = $signed({2'b00, e_big}) + 10'sd1;
      end else begin
         add_man = sum[26:0] << lz;
         add_exp = $signed({2'b00, e_big}) - $signed({5'd0, lz});
      end
      // Exact cancellation yields +0 under round-to-nearest.
      add_res = (sum == 28'd0) ? 32'd0 : round_pack(s_big, add_exp, add_man);
   end

   logic [47:0]       prod;
   logic [26:0]       mul_man;
   logic signed [9:0] mul_exp;

   always_comb begin
      prod    = ma * mb;
      mul_exp = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
      if (prod[47]) begin
         mul_man = {prod[47:22], |prod[21:0]};
         mul_exp = mul_exp + 10'sd1;
      end else begin
         mul_man = {prod[46:21], |prod[20:0]};
      end
   end

   logic [49:0]       num, den;
   logic [26:0]       quo, div_man;
   logic              rem_nz;
   logic signed [9:0] div_exp;

   always_comb begin
      num     = {ma, 26'd0};
      den     = {26'd0, mb};
      quo     = 27'(num / den);
      rem_nz  = |(num % den);
      div_exp = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
      if (quo[26]) begin
         div_man = {quo[26:1], quo[0] | rem_nz};
      end else begin
         div_man = {quo[25:0], rem_nz};
         div_exp = div_exp - 10'sd1;
      end
   end

   always_comb begin
      case (op_sel_i)
         OP_MUL:  result_o = round_pack(sa ^ sb, mul_exp, mul_man);
         OP_DIV:  result_o = round_pack(sa ^ sb, div_exp, div_man);
         default: result_o = add_res;
      endcase
   end

endmodule

// File: rtl/ieee754_op_sequencer.sv
// One-outstanding-operation sequencer: capture operands, resolve special/zero cases or take the
// arithmetic core result, then hold it until the consumer takes it.
module ieee754_op_sequencer
   import ieee754_op_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [1:0]  in_op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [2:0]  out_flags,
   output logic [15:0] op_count,
   output logic [1:0]  dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid never waits on ready, and payload is held stable while valid is high without ready.

   state_e      state_q;
   logic        in_ready_q, out_valid_q;
   logic [31:0] a_q, b_q, result_q;
   op_e         op_q;
   logic [2:0]  flags_q;
   logic [15:0] op_count_q;

   logic [31:0] core_res, result_d;
   logic [2:0]  flags_d;

   ieee754_op_sequencer_core u_core (
      .a_i      (a_q),
      .b_i      (b_q),
      .op_sel_i (op_q),
      .result_o (core_res)
   );

   logic a_ni, b_ni, a_zero, b_zero, s_xor;

   assign a_ni   = a_q[30:23] == EXP_MAX;
   assign b_ni   = b_q[30:23] == EXP_MAX;
   assign a_zero = a_q[30:23] == 8'd0;
   assign b_zero = b_q[30:23] == 8'd0;
   assign s_xor  = a_q[31] ^ b_q[31];

   always_comb begin
      result_d = core_res;
      flags_d  = '0;
      if (a_ni || b_ni) begin
         result_d               = QNAN;
         flags_d[FLAG_INVALID]  = 1'b1;
         flags_d[FLAG_BYPASS]   = 1'b1;
      end else if (a_zero || b_zero) begin
         // Denormals land here too: they are treated as zeros.
         flags_d[FLAG_BYPASS] = 1'b1;
         case (op_q)
            OP_ADD, OP_SUB: begin
               if (a_zero && b_zero)
                  result_d = 32'd0;
               else if (a_zero)
                  result_d = (op_q == OP_SUB) ? {~b_q[31], b_q[30:0]} : b_q;
               else
                  result_d = a_q;
            end
            OP_MUL: result_d = {s_xor, 31'd0};
            default: begin
               if (a_zero && b_zero) begin
                  result_d              = QNAN;
                  flags_d[FLAG_INVALID] = 1'b1;
               end else if (b_zero) begin
                  result_d               = {s_xor, PINF[30:0]};
                  flags_d[FLAG_DIV_ZERO] = 1'b1;
               end else begin
                  result_d = {s_xor, 31'd0};
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= OP_ADD;
         result_q    <= '0;
         flags_q     <= '0;
         op_count_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= in_a;
                  b_q        <= in_b;
                  op_q       <= op_e'(in_op);
                  in_ready_q <= 1'b0;
                  state_q    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               result_q    <= result_d;
               flags_q     <= flags_d;
               out_valid_q <= 1'b1;
               state_q     <= ST_DONE;
            end
            ST_DONE: begin
               // in_ready stays low here, so a request arriving with out_ready waits for IDLE.
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  op_count_q  <= op_count_q + 16'd1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_result  = result_q;
   assign out_flags   = flags_q;
   assign op_count    = op_count_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ieee754_op_sequencer.sv
// Directed bench for ieee754_op_sequencer: hand-computed vectors checked with immediate assertions.
module tb_ieee754_op_sequencer;
   import ieee754_op_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] in_a, in_b;
   logic [1:0]  in_op;
   logic        out_valid, out_ready;
   logic [31:0] out_result;
   logic [2:0]  out_flags;
   logic [15:0] op_count;
   logic [1:0]  dbg_state;

   int          passed = 0;
   int          failed = 0;
   int          total  = 0;
   logic [15:0] exp_cnt;

   ieee754_op_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_op       (in_op),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_flags   (out_flags),
      .op_count    (op_count),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled on the falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op);
      in_a     = a;
      in_b     = b;
      in_op    = op;
      in_valid = 1'b1;
      check({tag, "_ready_before"}, 32'(in_ready), 32'd1);
      cyc();
      in_valid = 1'b0;
      check({tag, "_exec_state"}, 32'(dbg_state), 32'(ST_EXEC));
      check({tag, "_valid_cycle1"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_exec"}, 32'(in_ready), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [31:0] exp_res, input logic [2:0] exp_flg);
      out_ready = 1'b1;
      send(tag, a, b, op);
      cyc();
      check({tag, "_valid_cycle2"}, 32'(out_valid), 32'd1);
      check({tag, "_result"}, out_result, exp_res);
      check({tag, "_flags"}, 32'(out_flags), 32'(exp_flg));
      cyc();
      exp_cnt = exp_cnt + 16'd1;
      check({tag, "_count"}, 32'(op_count), 32'(exp_cnt));
      check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
      check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_op     = '0;
      out_ready = 1'b0;
      exp_cnt   = 16'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_result", out_result, 32'd0);
      check("rst_flags", 32'(out_flags), 32'd0);
      check("rst_count", 32'(op_count), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b0;
      cyc();

      // 1.5 + 2.5 = 4.0
      run_op("add", 32'h3FC0_0000, 32'h4020_0000, OP_ADD, 32'h4080_0000, 3'b000);

      // 2.0 * 3.0 = 6.0 held under backpressure
      out_ready = 1'b0;
      send("mul_bp", 32'h4000_0000, 32'h4040_0000, OP_MUL);
      cyc();
      for (int i = 0; i < 5; i++) begin
         check("mul_bp_valid", 32'(out_valid), 32'd1);
         check("mul_bp_result", out_result, 32'h40C0_0000);
         check("mul_bp_flags", 32'(out_flags), 32'd0);
         check("mul_bp_in_ready", 32'(in_ready), 32'd0);
         check("mul_bp_count", 32'(op_count), 32'(exp_cnt));
         cyc();
      end
      // Release while a new request (1.0 + 1.0) is already waiting: it must not be taken in DONE.
      out_ready = 1'b1;
      in_a      = 32'h3F80_0000;
      in_b      = 32'h3F80_0000;
      in_op     = OP_ADD;
      in_valid  = 1'b1;
      check("done_in_ready", 32'(in_ready), 32'd0);
      check("done_result", out_result, 32'h40C0_0000);
      cyc();
      exp_cnt = exp_cnt + 16'd1;
      check("mul_bp_count_inc", 32'(op_count), 32'(exp_cnt));
      check("pending_idle", 32'(dbg_state), 32'(ST_IDLE));
      check("pending_valid_low", 32'(out_valid), 32'd0);
      check("pending_in_ready", 32'(in_ready), 32'd1);
      cyc();
      in_valid = 1'b0;
      check("pending_accepted", 32'(dbg_state), 32'(ST_EXEC));
      cyc();
      check("pending_valid", 32'(out_valid), 32'd1);
      check("pending_result", out_result, 32'h4000_0000);
      check("pending_flags", 32'(out_flags), 32'd0);
      cyc();
      exp_cnt = exp_cnt + 16'd1;
      check("pending_count", 32'(op_count), 32'(exp_cnt));

      run_op("div_by_zero", 32'h3F80_0000, 32'h0000_0000, OP_DIV, 32'h7F80_0000, 3'b011);
      run_op("div_zero_zero", 32'h8000_0000, 32'h0000_0000, OP_DIV, 32'h7FC0_0000, 3'b101);
      run_op("nan_add", 32'h7FC0_0001, 32'h3F80_0000, OP_ADD, 32'h7FC0_0000, 3'b101);
      run_op("zero_sub", 32'h0000_0000, 32'h4000_0000, OP_SUB, 32'hC000_0000, 3'b001);
      run_op("sub_norm", 32'h4040_0000, 32'h3F80_0000, OP_SUB, 32'h4000_0000, 3'b000);
      run_op("div_norm", 32'h40C0_0000, 32'h4000_0000, OP_DIV, 32'h4040_0000, 3'b000);
      run_op("mul_zero", 32'h8000_0000, 32'h4000_0000, OP_MUL, 32'h8000_0000, 3'b001);
      run_op("denorm_add", 32'h0000_0001, 32'h3F80_0000, OP_ADD, 32'h3F80_0000, 3'b001);
      run_op("add_b_zero", 32'h4000_0000, 32'h8000_0000, OP_ADD, 32'h4000_0000, 3'b001);
      run_op("zero_div", 32'h0000_0000, 32'hC000_0000, OP_DIV, 32'h8000_0000, 3'b001);
      run_op("inf_mul", 32'h7F80_0000, 32'h3F80_0000, OP_MUL, 32'h7FC0_0000, 3'b101);

      // Reset during EXEC aborts the operation.
      out_ready = 1'b1;
      send("abort", 32'h3FC0_0000, 32'h4020_0000, OP_ADD);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_result", out_result, 32'd0);
      check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
      exp_cnt = 16'd0;
      check("abort_count", 32'(op_count), 32'(exp_cnt));
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("abort_no_valid", 32'(out_valid), 32'd0);
         check("abort_count_hold", 32'(op_count), 32'(exp_cnt));
      end

      // Counter wrap: preload near the top instead of running 65536 operations.
      force dut.op_count_q = 16'hFFFE;
      #1;
      release dut.op_count_q;
      exp_cnt = 16'hFFFE;
      check("wrap_preload", 32'(op_count), 32'(exp_cnt));
      run_op("wrap_ffff", 32'h3F80_0000, 32'h3F80_0000, OP_ADD, 32'h4000_0000, 3'b000);
      run_op("wrap_zero", 32'h3F80_0000, 32'h3F80_0000, OP_ADD, 32'h4000_0000, 3'b000);
      check("wrap_count_zero", 32'(op_count), 32'h0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
